// File: rtl/regfile_mp.sv
// Multi-port register file: 2**N words of W bits, NR combinational read ports, byte-enabled write
// and a sequenced whole-file clear. Define REGFILE_MP_BYPASS_EN to forward same-cycle writes to reads.
module regfile_mp #(
    parameter int N  = 4,
    parameter int W  = 32,
    parameter int NR = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [N-1:0]    addr_rd,
    input  logic [W-1:0]    data_in,
    input  logic [W/8-1:0]  be,
    input  logic [NR*N-1:0] addr_rs,
    output logic [NR*W-1:0] rs,
    input  logic            clr_req,
    output logic            clr_busy,
    output logic            clr_done
);
    localparam int DEPTH = 1 << N;
    localparam int NB    = W / 8;

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

    state_t         state_reg;
    logic [N-1:0]   ptr_reg;
    logic           clr_busy_reg;
    logic           clr_done_reg;

    logic [W-1:0]   regs [DEPTH];
    logic [W-1:0]   be_mask;
    logic [W-1:0]   wr_merged;
    logic           wr_en;
    logic           clr_en;

    // Writes are dropped for the whole busy window, including the DONE cycle.
    assign wr_en  = we && !clr_busy_reg && (addr_rd != '0);
    assign clr_en = (state_reg == CLEAR);

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_mask
            assign be_mask[gi*8 +: 8] = {8{be[gi]}};
        end
    endgenerate

    assign wr_merged = (data_in & be_mask) | (regs[addr_rd] & ~be_mask);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            ptr_reg      <= '0;
            clr_busy_reg <= 1'b0;
            clr_done_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    clr_done_reg <= 1'b0;
                    if (clr_req) begin
                        state_reg    <= CLEAR;
                        ptr_reg      <= N'(1);
                        clr_busy_reg <= 1'b1;
                    end
                end
                CLEAR: begin
                    // The last address terminates the sweep; the pointer parks there.
                    if (ptr_reg == '1) begin
                        state_reg    <= DONE;
                        clr_done_reg <= 1'b1;
                    end else begin
                        ptr_reg <= ptr_reg + N'(1);
                    end
                end
                DONE: begin
                    state_reg    <= IDLE;
                    clr_busy_reg <= 1'b0;
                    clr_done_reg <= 1'b0;
                end
                default: begin
                    state_reg    <= IDLE;
                    clr_busy_reg <= 1'b0;
                    clr_done_reg <= 1'b0;
                end
            endcase
        end
    end

    assign clr_busy = clr_busy_reg;
    assign clr_done = clr_done_reg;

    // Register 0 is hardwired to zero; the rest are flops so reset can clear them at once.
    assign regs[0] = '0;
    generate
        for (gi = 1; gi < DEPTH; gi++) begin : g_reg
            logic [W-1:0] q_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q_reg <= '0;
                end else if (clr_en && (ptr_reg == N'(gi))) begin
                    q_reg <= '0;
                end else if (wr_en && (addr_rd == N'(gi))) begin
                    q_reg <= wr_merged;
                end
            end
            assign regs[gi] = q_reg;
        end
    endgenerate

    generate
        for (gi = 0; gi < NR; gi++) begin : g_rd
            logic [N-1:0] ra;
            logic [W-1:0] rd;
            assign ra = addr_rs[gi*N +: N];
`ifdef REGFILE_MP_BYPASS_EN
            assign rd = (wr_en && (ra == addr_rd)) ? wr_merged : regs[ra];
`else
            assign rd = regs[ra];
`endif
            assign rs[gi*W +: W] = rst_n ? rd : '0;
        end
    endgenerate
endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter N, default 4: address bits; 2**N registers.
REQ-002 SHALL have parameter W, default 32: word width; a multiple of 8.
REQ-003 SHALL have parameter NR, default 3: number of read ports, 1 to 4.
REQ-004 SHALL have port clk, input, 1 bit: single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port we, input, 1 bit: write enable.
REQ-007 SHALL have port addr_rd, input, N bits: write address.
REQ-008 SHALL have port data_in, input, W bits: write data.
REQ-009 SHALL have port be, input, W/8 bits: byte enables; bit i gates data_in[8i+7:8i].
REQ-010 SHALL have port addr_rs, input, NR*N bits: read addresses; port k is bits [kN+N-1:kN].
REQ-011 SHALL have port rs, output, NR*W bits: read data; port k is bits [kW+W-1:kW].
REQ-012 SHALL have port clr_req, input, 1 bit: request to clear the whole file.
REQ-013 SHALL have port clr_busy, output, 1 bit: clear sequence in progress.
REQ-014 SHALL have port clr_done, output, 1 bit: one-cycle pulse when the clear completes.

Function
REQ-015 SHALL read all ports combinationally: rs[k] = regs[addr_rs[k]].
REQ-016 SHALL always return 0 on any read port addressing register 0.
REQ-017 SHALL write on the clock edge when we=1, clr_busy=0 and addr_rd!=0, updating only the bytes enabled by be.
REQ-018 SHALL make a write with be=0 or addr_rd=0 change no state.
REQ-019 SHALL implement a clear FSM with states IDLE, CLEAR and DONE.
REQ-020 SHALL move from IDLE to CLEAR on clr_req=1, with the clear pointer loaded to 1.
REQ-021 SHALL, in CLEAR, zero regs[ptr] each cycle and increment ptr.
REQ-022 SHALL, in CLEAR, go to DONE after clearing address 2**N-1; this wrap point ends the sequence and ptr does not wrap to 0.
REQ-023 SHALL spend one cycle in DONE, then return to IDLE.
REQ-024 SHALL make a clear take exactly 2**N-1 cycles in CLEAR.
REQ-025 SHALL assert clr_busy in CLEAR and DONE.
REQ-026 SHALL assert clr_done only in DONE.
REQ-027 SHALL ignore writes presented while clr_busy=1; they are dropped and not queued.
REQ-028 SHALL ignore clr_req while clr_busy=1.
REQ-029 SHALL, when we=1 and clr_req=1 in the same IDLE cycle, perform the write and start the clear; the written register is cleared later in the sequence.
REQ-030 SHALL let reads during a clear return current contents: already-cleared registers read 0, the rest read their old values.
REQ-031 SHALL give a read and write to the same address in one cycle the pre-write value, unless the bypass feature is compiled in.

Reset
REQ-032 SHALL, while rst_n=0, immediately and asynchronously zero all registers, put the FSM in IDLE, set ptr=0, and drive clr_busy=0 and clr_done=0.
REQ-033 SHALL, on rst_n asserted mid-clear, abort the sequence with no clr_done pulse.
REQ-034 SHALL drive rs to 0 on all ports while in reset.
REQ-035 SHALL resume operation on the first rising clk edge after rst_n deasserts.

Configuration
REQ-036 SHALL provide macro REGFILE_MP_BYPASS_EN.
REQ-037 SHALL, with REGFILE_MP_BYPASS_EN defined, return the byte-merged new value on read port k when addr_rs[k]==addr_rd, we=1, clr_busy=0 and addr_rd!=0. The enabled bytes come from data_in; the other bytes come from the stored value.
REQ-038 SHALL, with REGFILE_MP_BYPASS_EN undefined, add no forwarding logic and follow REQ-031.

Verification
REQ-039 SHALL cover: reset released; write reg3=0xDEADBEEF with be=4'hF; read on all ports -> 0xDEADBEEF. Write to reg0 -> reads 0.
REQ-040 SHALL cover: reg5=0x11223344, then write 0xAABBCCDD with be=4'b0101 -> reg5 reads 0x11BB33DD.
REQ-041 SHALL cover: N=4, pulse clr_req -> clr_busy high 16 cycles (15 CLEAR + 1 DONE), clr_done pulses once, all registers read 0, and a write issued mid-clear is lost.
REQ-042 SHALL cover: same-cycle write 0x5 and read of reg7, where reg7 held 0x9 -> read 0x9 without the macro, 0x5 with REGFILE_MP_BYPASS_EN.
REQ-043 SHALL cover: rst_n pulled low at cycle 6 of a clear -> asynchronous zeroing, clr_busy=0, no clr_done, FSM in IDLE.
REQ-044 SHALL cover: we and clr_req together in IDLE -> clear proceeds and the target register ends at 0.
